// File: rtl/clip_record_play_ctrl_if.sv
// ----------------------------------------------------------------------------
// clip_record_play_ctrl_if
// Bundles the control, strobe and BRAM-side signals of the clip record/play
// sequencer.
//   master : drives the buttons, clip selects and sample strobe, observes
//            the enables, address and status.
//   slave  : the sequencer itself.
// Optional Loop input exists only when LOOP_PLAY_EN is defined.
// ----------------------------------------------------------------------------
interface clip_record_play_ctrl_if #(
    parameter int unsigned NUM_CLIPS  = 2,
    parameter int unsigned CLIP_SEL_W = 1,
    parameter int unsigned ADDR_W     = 17
);
    // Control inputs to the sequencer
    logic                  Record;
    logic                  Play;
    logic                  Stop;
    logic [CLIP_SEL_W-1:0] Clip_no_r;
    logic [CLIP_SEL_W-1:0] Clip_no_p;
    logic                  sample_tick;
`ifdef LOOP_PLAY_EN
    logic                  Loop;
`endif

    // Sequencer outputs
    logic                  D_enable;
    logic                  S_enable;
    logic [NUM_CLIPS-1:0]  mem_en;
    logic                  mem_w_enable;
    logic [ADDR_W-1:0]     mem_addr;
    logic [NUM_CLIPS-1:0]  clip_valid;
    logic                  busy;
    logic                  done;

    modport master (
`ifdef LOOP_PLAY_EN
        output Loop,
`endif
        output Record, Play, Stop, Clip_no_r, Clip_no_p, sample_tick,
        input  D_enable, S_enable, mem_en, mem_w_enable, mem_addr,
        input  clip_valid, busy, done
    );

    modport slave (
`ifdef LOOP_PLAY_EN
        input  Loop,
`endif
        input  Record, Play, Stop, Clip_no_r, Clip_no_p, sample_tick,
        output D_enable, S_enable, mem_en, mem_w_enable, mem_addr,
        output clip_valid, busy, done
    );
endinterface

// File: rtl/clip_record_play_ctrl.sv
// ----------------------------------------------------------------------------
// clip_record_play_ctrl
// Record/playback sequencer for NUM_CLIPS clip BRAMs with variable-length
// takes. An internal sample counter advances on each sample_tick; each clip
// keeps its recorded length so playback stops at the last recorded sample.
//
// Ports:
//   clock_i  : system clock
//   Reset_n  : asynchronous active-low reset
//   bus      : clip_record_play_ctrl_if.slave
//              in : Record, Play, Stop, Clip_no_r, Clip_no_p, sample_tick,
//                   Loop (only with LOOP_PLAY_EN)
//              out: D_enable, S_enable, mem_en (one-hot), mem_w_enable,
//                   mem_addr, clip_valid, busy, done
//
// Configuration macro: LOOP_PLAY_EN -- when defined, Loop=1 makes playback
// wrap to address 0 at the end of the clip instead of finishing.
//
// All outputs are registered and change on the same edge as the state.
// ----------------------------------------------------------------------------
module clip_record_play_ctrl #(
    parameter int unsigned NUM_CLIPS  = 2,
    parameter int unsigned CLIP_SEL_W = 1,
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned CLIP_LEN   = 100000
) (
    input logic                    clock_i,
    input logic                    Reset_n,
    clip_record_play_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(CLIP_LEN - 1);
    localparam logic [ADDR_W:0]   FullLen  = (ADDR_W + 1)'(CLIP_LEN);
    localparam logic [ADDR_W:0]   LenOne   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {StIdle, StRec, StPlay, StFin} state_e;

    state_e                state_q, state_d;
    logic [CLIP_SEL_W-1:0] act_clip_q, act_clip_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [ADDR_W:0]       len_q [NUM_CLIPS];
    logic [ADDR_W:0]       len_d [NUM_CLIPS];
    logic [NUM_CLIPS-1:0]  clip_valid_q, clip_valid_d;

    // Registered outputs
    logic                  d_enable_q, d_enable_d;
    logic                  s_enable_q, s_enable_d;
    logic [NUM_CLIPS-1:0]  mem_en_q, mem_en_d;
    logic                  mem_w_enable_q, mem_w_enable_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Input qualification
    logic            rec_sel_ok;
    logic            play_sel_ok;
    logic            play_clip_ok;
    logic            loop_en;
    logic [ADDR_W:0] addr_plus1;
    logic [ADDR_W:0] cur_len;
    logic            play_last;

    assign rec_sel_ok   = 32'(bus.Clip_no_r) < NUM_CLIPS;
    assign play_sel_ok  = 32'(bus.Clip_no_p) < NUM_CLIPS;
    assign play_clip_ok = play_sel_ok && clip_valid_q[bus.Clip_no_p];

`ifdef LOOP_PLAY_EN
    assign loop_en = bus.Loop;
`else
    assign loop_en = 1'b0;
`endif

    // One extra bit so a full-length take (CLIP_LEN == 2**ADDR_W) is representable.
    assign addr_plus1 = {1'b0, mem_addr_q} + LenOne;
    assign cur_len    = len_q[act_clip_q];
    assign play_last  = (addr_plus1 == cur_len);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        act_clip_d   = act_clip_q;
        mem_addr_d   = mem_addr_q;
        len_d        = len_q;
        clip_valid_d = clip_valid_q;

        case (state_q)
            StIdle: begin
                // Record outranks Play when both are requested.
                if (bus.Record && rec_sel_ok) begin
                    state_d    = StRec;
                    act_clip_d = bus.Clip_no_r;
                    mem_addr_d = '0;
                end else if (bus.Play && play_clip_ok) begin
                    state_d    = StPlay;
                    act_clip_d = bus.Clip_no_p;
                    mem_addr_d = '0;
                end
            end

            StRec: begin
                if (bus.Stop) begin
                    // A tick coinciding with Stop still counts as a recorded sample.
                    state_d    = StFin;
                    mem_addr_d = '0;
                    len_d[act_clip_q] = bus.sample_tick ? addr_plus1 : {1'b0, mem_addr_q};
                end else if (bus.sample_tick) begin
                    if (mem_addr_q == LastAddr) begin
                        state_d           = StFin;
                        mem_addr_d        = '0;
                        len_d[act_clip_q] = FullLen;
                    end else begin
                        mem_addr_d = addr_plus1[ADDR_W-1:0];
                    end
                end
            end

            StPlay: begin
                if (bus.Stop) begin
                    state_d    = StFin;
                    mem_addr_d = '0;
                end else if (bus.sample_tick) begin
                    if (play_last) begin
                        mem_addr_d = '0;
                        if (!loop_en) begin
                            state_d = StFin;
                        end
                    end else begin
                        mem_addr_d = addr_plus1[ADDR_W-1:0];
                    end
                end
            end

            StFin: begin
                state_d    = StIdle;
                mem_addr_d = '0;
            end

            default: begin
                state_d    = StIdle;
                mem_addr_d = '0;
            end
        endcase

        // Validity follows the length written on entry to FIN; an empty take clears the clip.
        if (state_d == StFin && state_q != StFin) begin
            clip_valid_d[act_clip_q] = (len_d[act_clip_q] != '0);
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, so the registered outputs track
    // the state register edge for edge.
    // ------------------------------------------------------------------
    always_comb begin
        d_enable_d     = 1'b0;
        s_enable_d     = 1'b0;
        mem_en_d       = '0;
        mem_w_enable_d = 1'b0;
        done_d         = 1'b0;
        busy_d         = (state_d != StIdle);

        case (state_d)
            StRec: begin
                d_enable_d           = 1'b1;
                mem_w_enable_d       = 1'b1;
                mem_en_d[act_clip_d] = 1'b1;
            end
            StPlay: begin
                d_enable_d           = 1'b1;
                s_enable_d           = 1'b1;
                mem_en_d[act_clip_d] = 1'b1;
            end
            StFin: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge Reset_n) begin
        if (!Reset_n) begin
            act_clip_q     <= '0;
            mem_addr_q     <= '0;
            clip_valid_q   <= '0;
            d_enable_q     <= 1'b0;
            s_enable_q     <= 1'b0;
            mem_en_q       <= '0;
            mem_w_enable_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            for (int i = 0; i < int'(NUM_CLIPS); i++) begin
                len_q[i] <= '0;
            end
        end else begin
            act_clip_q     <= act_clip_d;
            mem_addr_q     <= mem_addr_d;
            clip_valid_q   <= clip_valid_d;
            d_enable_q     <= d_enable_d;
            s_enable_q     <= s_enable_d;
            mem_en_q       <= mem_en_d;
            mem_w_enable_q <= mem_w_enable_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            for (int i = 0; i < int'(NUM_CLIPS); i++) begin
                len_q[i] <= len_d[i];
            end
        end
    end

    assign bus.D_enable     = d_enable_q;
    assign bus.S_enable     = s_enable_q;
    assign bus.mem_en       = mem_en_q;
    assign bus.mem_w_enable = mem_w_enable_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.clip_valid   = clip_valid_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_clip_record_play_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clip_record_play_ctrl
// Directed bench for clip_record_play_ctrl with NUM_CLIPS=4, ADDR_W=4,
// CLIP_LEN=8. Inputs change 1 time unit after a rising edge; outputs are
// checked at the same offset after the following edge.
// ----------------------------------------------------------------------------
module tb_clip_record_play_ctrl;

    localparam int unsigned NClips = 4;
    localparam int unsigned SelW   = 2;
    localparam int unsigned AddrW  = 4;
    localparam int unsigned ClipLen = 8;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    clip_record_play_ctrl_if #(
        .NUM_CLIPS (NClips),
        .CLIP_SEL_W(SelW),
        .ADDR_W    (AddrW)
    ) bus ();

    clip_record_play_ctrl #(
        .NUM_CLIPS (NClips),
        .CLIP_SEL_W(SelW),
        .ADDR_W    (AddrW),
        .CLIP_LEN  (ClipLen)
    ) dut (
        .clock_i(clk),
        .Reset_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle tick (optionally with Stop) followed by release.
    task automatic tick(input logic with_stop);
        bus.sample_tick = 1'b1;
        bus.Stop        = with_stop;
        step();
        bus.sample_tick = 1'b0;
        bus.Stop        = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.Record      = 1'b0;
        bus.Play        = 1'b0;
        bus.Stop        = 1'b0;
        bus.Clip_no_r   = '0;
        bus.Clip_no_p   = '0;
        bus.sample_tick = 1'b0;
`ifdef LOOP_PLAY_EN
        bus.Loop        = 1'b0;
`endif
        step();
        step();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);
        chk("rst_valid", 32'(bus.clip_valid), 0);
        chk("rst_en", 32'({bus.D_enable, bus.S_enable, bus.mem_w_enable}), 0);
        rst_n = 1'b1;
        step();

        // Play into an empty clip is ignored
        bus.Play = 1'b1; bus.Clip_no_p = 2'd3;
        step();
        bus.Play = 1'b0;
        chk("empty_play_busy", 32'(bus.busy), 0);
        chk("empty_play_done", 32'(bus.done), 0);
        chk("empty_play_en", 32'({bus.mem_en, bus.D_enable, bus.S_enable, bus.mem_w_enable}), 0);

        // Full-length take into clip 2
        bus.Record = 1'b1; bus.Clip_no_r = 2'd2;
        step();
        bus.Record = 1'b0;
        chk("rec2_mem_en", 32'(bus.mem_en), 32'h4);
        chk("rec2_we", 32'(bus.mem_w_enable), 1);
        chk("rec2_d_s", 32'({bus.D_enable, bus.S_enable}), 32'h2);
        chk("rec2_busy", 32'(bus.busy), 1);
        for (int i = 0; i < 8; i++) begin
            chk("rec2_addr", 32'(bus.mem_addr), 32'(i));
            chk("rec2_nodone", 32'(bus.done), 0);
            tick(1'b0);
        end
        chk("rec2_done", 32'(bus.done), 1);
        chk("rec2_fin_addr", 32'(bus.mem_addr), 0);
        chk("rec2_fin_en", 32'({bus.mem_en, bus.mem_w_enable, bus.D_enable}), 0);
        chk("rec2_valid", 32'(bus.clip_valid), 32'h4);
        step();
        chk("rec2_idle_done", 32'(bus.done), 0);
        chk("rec2_idle_busy", 32'(bus.busy), 0);

        // Clip 1, Stop coincident with third tick -> length 3
        bus.Record = 1'b1; bus.Clip_no_r = 2'd1;
        step();
        bus.Record = 1'b0;
        chk("rec1_mem_en", 32'(bus.mem_en), 32'h2);
        tick(1'b0);
        tick(1'b0);
        chk("rec1_addr2", 32'(bus.mem_addr), 2);
        tick(1'b1);
        chk("rec1_stop_done", 32'(bus.done), 1);
        chk("rec1_valid", 32'(bus.clip_valid), 32'h6);
        step();
        bus.Play = 1'b1; bus.Clip_no_p = 2'd1;
        step();
        bus.Play = 1'b0;
        chk("play1_en", 32'({bus.D_enable, bus.S_enable, bus.mem_w_enable}), 32'h6);
        chk("play1_mem_en", 32'(bus.mem_en), 32'h2);
        chk("play1_addr0", 32'(bus.mem_addr), 0);
        tick(1'b0);
        chk("play1_addr1", 32'(bus.mem_addr), 1);
        tick(1'b0);
        chk("play1_addr2", 32'(bus.mem_addr), 2);
        chk("play1_nodone", 32'(bus.done), 0);
        tick(1'b0);
        chk("play1_done", 32'(bus.done), 1);
        chk("play1_s_off", 32'(bus.S_enable), 0);
        chk("play1_fin_addr", 32'(bus.mem_addr), 0);
        step();
        chk("play1_idle", 32'(bus.busy), 0);

        // Record and Play together: Record wins; Play mid-take ignored
        bus.Record = 1'b1; bus.Play = 1'b1; bus.Clip_no_r = 2'd0; bus.Clip_no_p = 2'd2;
        step();
        bus.Record = 1'b0; bus.Play = 1'b0;
        chk("both_we", 32'(bus.mem_w_enable), 1);
        chk("both_s", 32'(bus.S_enable), 0);
        chk("both_mem_en", 32'(bus.mem_en), 32'h1);
        tick(1'b0);
        bus.Play = 1'b1; bus.Clip_no_p = 2'd1;
        step();
        bus.Play = 1'b0;
        chk("midplay_we", 32'(bus.mem_w_enable), 1);
        chk("midplay_mem_en", 32'(bus.mem_en), 32'h1);
        chk("midplay_addr", 32'(bus.mem_addr), 1);
        for (int i = 0; i < 4; i++) tick(1'b0);
        chk("pre_rst_addr", 32'(bus.mem_addr), 5);

        // Asynchronous reset in the middle of a take
        #1 rst_n = 1'b0;
        #1;
        chk("async_en", 32'({bus.mem_en, bus.D_enable, bus.S_enable, bus.mem_w_enable}), 0);
        chk("async_addr", 32'(bus.mem_addr), 0);
        chk("async_busy", 32'(bus.busy), 0);
        chk("async_valid", 32'(bus.clip_valid), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", 32'(bus.busy), 0);
        bus.Play = 1'b1; bus.Clip_no_p = 2'd2;
        step();
        bus.Play = 1'b0;
        chk("post_rst_play_ign", 32'(bus.busy), 0);

        // One-sample take into clip 0, then an empty re-take clears it
        bus.Record = 1'b1; bus.Clip_no_r = 2'd0;
        step();
        bus.Record = 1'b0;
        tick(1'b0);
        bus.Stop = 1'b1;
        step();
        bus.Stop = 1'b0;
        chk("one_done", 32'(bus.done), 1);
        chk("one_valid", 32'(bus.clip_valid), 32'h1);
        step();
        bus.Record = 1'b1; bus.Clip_no_r = 2'd0;
        step();
        bus.Record = 1'b0;
        bus.Stop = 1'b1;
        step();
        bus.Stop = 1'b0;
        chk("empty_done", 32'(bus.done), 1);
        chk("empty_valid", 32'(bus.clip_valid), 0);
        step();

`ifdef LOOP_PLAY_EN
        // Three-sample take into clip 3, then looped playback
        bus.Record = 1'b1; bus.Clip_no_r = 2'd3;
        step();
        bus.Record = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0);
        bus.Stop = 1'b1;
        step();
        bus.Stop = 1'b0;
        chk("loop_rec_valid", 32'(bus.clip_valid), 32'h8);
        step();
        bus.Loop = 1'b1;
        bus.Play = 1'b1; bus.Clip_no_p = 2'd3;
        step();
        bus.Play = 1'b0;
        chk("loop_addr_start", 32'(bus.mem_addr), 0);
        for (int i = 1; i <= 7; i++) begin
            tick(1'b0);
            chk("loop_addr", 32'(bus.mem_addr), 32'(i % 3));
            chk("loop_nodone", 32'(bus.done), 0);
            chk("loop_s_en", 32'(bus.S_enable), 1);
        end
        bus.Stop = 1'b1;
        step();
        bus.Stop = 1'b0;
        chk("loop_stop_done", 32'(bus.done), 1);
        chk("loop_stop_addr", 32'(bus.mem_addr), 0);
        bus.Loop = 1'b0;
        step();
        chk("loop_idle", 32'(bus.busy), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
